// File: rtl/fetch_redirect_unit.sv
// LC-3b instruction-fetch front end: owns the PC, issues one imem read at a time,
// buffers up to two words (slot + skid) across stalls, and squashes wrong-path fetches.
module fetch_redirect_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [15:0] inst_pc_plus2
);

    typedef enum logic [1:0] {S_START, S_FETCH, S_SQUASH, S_FULL} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] target;
    logic [15:0] skid_inst;
    logic [15:0] skid_pc;
    logic        eff_redirect;
    logic        consumed;

    always_comb begin
        eff_redirect = redirect & ~stall;
        consumed     = inst_valid & ~stall & ~redirect;
        imem_read    = (state == S_FETCH) || (state == S_SQUASH);
        imem_address = pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_START;
            pc            <= RESET_PC;
            target        <= '0;
            inst_valid    <= 1'b0;
            inst          <= '0;
            inst_pc       <= '0;
            inst_pc_plus2 <= 16'h0002;
            skid_inst     <= '0;
            skid_pc       <= '0;
        end else begin
            // Default drain; a slot load later in this block overrides the clear.
            if (eff_redirect || consumed)
                inst_valid <= 1'b0;
            if (eff_redirect) begin
                skid_inst <= '0;
                skid_pc   <= '0;
            end
            case (state)
                S_START: state <= S_FETCH;
                S_FETCH: begin
                    if (eff_redirect) begin
                        if (imem_resp) begin
                            pc <= redirect_pc;
                        end else begin
                            target <= redirect_pc;
                            state  <= S_SQUASH;
                        end
                    end else if (imem_resp) begin
                        pc <= pc + 16'd2;
                        if (!inst_valid || !stall) begin
                            inst_valid    <= 1'b1;
                            inst          <= imem_rdata;
                            inst_pc       <= pc;
                            inst_pc_plus2 <= pc + 16'd2;
                        end else begin
                            skid_inst <= imem_rdata;
                            skid_pc   <= pc;
                            state     <= S_FULL;
                        end
                    end
                end
                S_SQUASH: begin
                    // Address stays at the old pc until the stale response drains.
                    if (imem_resp) begin
                        pc    <= eff_redirect ? redirect_pc : target;
                        state <= S_FETCH;
                    end else if (eff_redirect) begin
                        target <= redirect_pc;
                    end
                end
                S_FULL: begin
                    if (eff_redirect) begin
                        pc    <= redirect_pc;
                        state <= S_FETCH;
                    end else if (!stall) begin
                        inst_valid    <= 1'b1;
                        inst          <= skid_inst;
                        inst_pc       <= skid_pc;
                        inst_pc_plus2 <= skid_pc + 16'd2;
                        state         <= S_FETCH;
                    end
                end
                default: state <= S_START;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench: the reference model is the architectural fetch stream (program order,
// restarted on each effective redirect); a monitor pops and compares on every consumption.
module tb_fetch_redirect_unit;

    localparam logic [15:0] RPC = 16'h3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [15:0] inst_pc_plus2;

    always #5 clk = ~clk;

    fetch_redirect_unit #(.RESET_PC(RPC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_read(imem_read),
        .imem_address(imem_address),
        .imem_rdata(imem_rdata),
        .imem_resp(imem_resp),
        .inst_valid(inst_valid),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_pc_plus2(inst_pc_plus2)
    );

    typedef struct packed {
        logic [15:0] w;
        logic [15:0] a;
        logic [15:0] a2;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] next_a;
    int          tests = 0;
    int          fails = 0;
    int          consumed_n = 0;
    bit          busy = 1'b0;
    int unsigned rem = 0;
    int unsigned lat_max = 1;
    int unsigned lat_fix = 0;
    logic [15:0] req_addr = '0;
    bit          new_req = 1'b0;
    bit          prev_eff = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    function automatic void model_restart(input logic [15:0] a);
        exp_q.delete();
        next_a = a;
    endfunction

    function automatic void model_refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{mem_word(next_a), next_a, next_a + 16'd2});
            next_a = next_a + 16'd2;
        end
    endfunction

    // Memory: latches the address when a request starts, answers after its latency.
    task automatic mem_step();
        new_req    = 1'b0;
        imem_resp  = 1'b0;
        imem_rdata = 16'($urandom);
        if (!busy && imem_read) begin
            busy     = 1'b1;
            new_req  = 1'b1;
            req_addr = imem_address;
            rem      = (lat_fix != 0) ? lat_fix : $urandom_range(lat_max, 1);
        end
        if (busy) begin
            chk("read_held", 16'(imem_read), 16'h0001);
            chk("addr_stable", imem_address, req_addr);
            if (rem == 1) begin
                imem_resp  = 1'b1;
                imem_rdata = mem_word(req_addr);
                busy       = 1'b0;
            end else begin
                rem = rem - 1;
            end
        end
    endtask

    task automatic cycle(input bit s, input bit r, input logic [15:0] rpc);
        @(posedge clk);
        #1;
        mem_step();
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        if (r && !s)
            model_restart(rpc);
        model_refill();
    endtask

    task automatic wait_new_req(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1'b0, 1'b0, 16'h0000);
            if (new_req) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: no request within 20 cycles", name);
        end
    endtask

    task automatic wait_req(input string name, input logic [15:0] expa);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1'b0, 1'b0, 16'h0000);
            if (new_req) seen = 1'b1;
        end
        if (seen) begin
            chk(name, req_addr, expa);
        end else begin
            tests++;
            fails++;
            $display("FAIL %s: no request within 20 cycles", name);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_eff = 1'b0;
        end else begin
            if (prev_eff)
                chk("valid_after_redirect", 16'(inst_valid), 16'h0000);
            if (inst_valid && !stall && !redirect) begin
                consumed_n++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL order: got inst_pc %h expected none", inst_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, mon_e.a);
                    chk("inst", inst, mon_e.w);
                    chk("inst_pc_plus2", inst_pc_plus2, mon_e.a2);
                end
            end
            prev_eff = redirect && !stall;
        end
    end

    initial begin
        rst_n       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_resp   = 1'b0;
        imem_rdata  = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_read", 16'(imem_read), 16'h0000);
        chk("rst_valid", 16'(inst_valid), 16'h0000);
        chk("rst_inst_pc", inst_pc, 16'h0000);
        chk("rst_pc_plus2", inst_pc_plus2, 16'h0002);
        chk("rst_addr", imem_address, RPC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_restart(RPC);
        model_refill();

        // Start-up latency and skid behaviour under a 5-cycle stall.
        cycle(1'b0, 1'b0, 16'h0000);
        chk("first_read", 16'(imem_read), 16'h0001);
        chk("first_addr", imem_address, RPC);
        chk("not_yet_valid", 16'(inst_valid), 16'h0000);
        cycle(1'b1, 1'b0, 16'h0000);
        chk("first_valid", 16'(inst_valid), 16'h0001);
        chk("first_inst_pc", inst_pc, RPC);
        chk("second_addr", imem_address, RPC + 16'd2);
        cycle(1'b1, 1'b0, 16'h0000);
        chk("skid_no_read", 16'(imem_read), 16'h0000);
        repeat (3) cycle(1'b1, 1'b0, 16'h0000);
        chk("held_inst_pc", inst_pc, RPC);
        repeat (10) cycle(1'b0, 1'b0, 16'h0000);

        // Single redirect while a 3-cycle read is outstanding.
        lat_fix = 3;
        wait_new_req("pre_redirect");
        cycle(1'b0, 1'b1, 16'h4000);
        wait_req("redirect_addr", 16'h4000);
        repeat (6) cycle(1'b0, 1'b0, 16'h0000);

        // Two redirects during one outstanding read: the latest wins.
        lat_fix = 4;
        wait_new_req("pre_double");
        cycle(1'b0, 1'b1, 16'h4000);
        cycle(1'b0, 1'b1, 16'h5000);
        wait_req("double_redirect_addr", 16'h5000);
        repeat (6) cycle(1'b0, 1'b0, 16'h0000);

        // Redirect under stall is ignored, then honoured once stall is low.
        lat_fix = 2;
        cycle(1'b1, 1'b1, 16'h6000);
        repeat (6) cycle(1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 16'h6000);
        wait_req("unstalled_redirect", 16'h6000);
        repeat (4) cycle(1'b0, 1'b0, 16'h0000);

        // Wrap past 16'hFFFE.
        cycle(1'b0, 1'b1, 16'hFFFC);
        wait_req("wrap_a", 16'hFFFC);
        wait_req("wrap_b", 16'hFFFE);
        wait_req("wrap_c", 16'h0000);
        repeat (6) cycle(1'b0, 1'b0, 16'h0000);

        // Reset asserted while squashing.
        lat_fix = 4;
        wait_new_req("pre_squash");
        cycle(1'b0, 1'b1, 16'h7000);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        busy      = 1'b0;
        imem_resp = 1'b0;
        stall     = 1'b0;
        redirect  = 1'b0;
        #1;
        chk("squash_rst_read", 16'(imem_read), 16'h0000);
        chk("squash_rst_valid", 16'(inst_valid), 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_restart(RPC);
        model_refill();
        wait_req("restart_addr", RPC);

        // Randomised traffic.
        lat_fix = 0;
        lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 5, 16'($urandom));
        end
        cycle(1'b0, 1'b0, 16'h0000);

        tests++;
        if (consumed_n < 100) begin
            fails++;
            $display("FAIL throughput: got %0d consumed expected at least 100", consumed_n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Instruction-fetch front end of the LC-3b pipeline. It sits directly upstream of the branch/flush controller and owns the PC register. It issues one instruction-memory read at a time and buffers returned instructions across downstream stalls. It redirects the PC when a taken branch, JMP/RET, JSR/JSRR or TRAP resolves; any in-flight fetch is discarded so that the wrong-path word never reaches IF/ID.

## Interface
- RESET_PC, 16'h0000, first fetch address after reset.

- clk  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  global pipeline stall (same signal the flush controller sees).
- redirect  in  1  control transfer resolved taken (branch_enable | is_j | is_jsr | is_trap from MEM). Only honoured when stall=0.
- redirect_pc  in  16  target address, valid with redirect.
- imem_read  out  1  instruction-memory read request.
- imem_address  out  16  fetch address; stable while imem_read=1 until imem_resp.
- imem_rdata  in  16  returned instruction word, valid with imem_resp.
- imem_resp  in  1  one-cycle completion pulse for the outstanding read.
- inst_valid  out  1  output slot holds a valid instruction for IF/ID.
- inst  out  16  instruction word in the output slot.
- inst_pc  out  16  address of inst.
- inst_pc_plus2  out  16  inst_pc + 2, mod 2^16.

## Operation
- Registers: pc (16), target (16), output slot {valid, inst, pc}, skid entry {inst, pc}, state.
- Reset values: state=S_START, pc=RESET_PC, target=0, inst_valid=0, inst=0, inst_pc=0, inst_pc_plus2=2, skid cleared. imem_read=0 while in reset and in S_START.
- Slot consumed: inst_valid=1 & stall=0 & redirect=0. When consumed and not refilled the same cycle, inst_valid is 0 next cycle.
- Effective redirect: redirect=1 & stall=0. In every state it clears the slot and skid next cycle.
- imem_read and imem_address are a combinational decode of state and pc. Address is always pc.
- S_START: read=0. Go to S_FETCH next cycle.
- S_FETCH: read=1.
  - Effective redirect with imem_resp: discard rdata, pc<=redirect_pc, stay in S_FETCH. The new request starts next cycle.
  - Effective redirect without imem_resp: target<=redirect_pc, go to S_SQUASH. The address is held.
  - imem_resp, no redirect, slot free (inst_valid=0 or stall=0): slot<={rdata, pc}, pc<=pc+2, stay in S_FETCH.
  - imem_resp, no redirect, slot full and stall=1: skid<={rdata, pc}, pc<=pc+2, go to S_FULL.
- S_SQUASH: read=1 at the old pc, which is never changed mid-transaction.
  - A further effective redirect overwrites target; the latest redirect wins.
  - On imem_resp: discard rdata, pc<=target (or redirect_pc if a redirect arrives the same cycle), go to S_FETCH.
- S_FULL: read=0.
  - Effective redirect: clear slot and skid, pc<=redirect_pc, go to S_FETCH.
  - stall=0: slot<=skid, go to S_FETCH.
- PC arithmetic is unsigned 16-bit. 16'hFFFE+2 wraps to 16'h0000. Bit 0 of redirect_pc is passed through unmodified.
- rst_n low at any time immediately forces reset values. An in-flight memory response after reset is not expected; if imem_resp arrives in S_START it is ignored.

## Timing
- Fetch latency: imem_resp in cycle N gives inst_valid=1 with that word in N+1.
- Back-to-back requests: the next read is asserted in cycle N+1 with address pc+2.
- Redirect in cycle N: inst_valid=0 in N+1.
  - From S_FETCH with resp, or from S_FULL: imem_address=redirect_pc in N+1.
  - From S_FETCH without resp: redirect_pc is first presented the cycle after the old request's resp.
- At most one outstanding request. At most two buffered instructions (slot plus skid). No instruction is lost or duplicated across stalls.

## Test plan
- Reset, RESET_PC=16'h3000, 1-cycle memory: reads at 3000, 3002, 3004. inst_valid first high 2 cycles after rst_n rises. inst_pc_plus2 = inst_pc+2.
- stall high for 5 cycles while a fetch returns, with inst 3000 already in the slot: 3002 held in skid, imem_read=0. After stall drops, output order is 3000, 3002, 3004, with none dropped or repeated.
- Redirect to 16'h4000 while a 3-cycle read of 3006 is outstanding: 3006 word never appears, imem_address holds 3006 until resp, next read at 4000, first valid inst_pc=4000.
- Two redirects (4000, then 5000) during one outstanding read: only 5000 is fetched afterward.
- Redirect with stall=1: ignored, pc unchanged. The same redirect repeated with stall=0 takes effect.
- pc=16'hFFFE: next fetch address is 16'h0000, and inst_pc_plus2=16'h0000 for the FFFE word. Asserting rst_n low mid-S_SQUASH makes imem_read 0 immediately and restarts from RESET_PC.
